// File: rtl/rtc_bus_seq_arb.sv
// N-channel arbiter and timed sequencer for the multiplexed parallel RTC bus.
// Define RTC_RR_ARB_EN for round-robin arbitration; otherwise lowest index wins.
module rtc_bus_seq_arb #(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 8,
  parameter int T_PULSE = 4,
  parameter int T_GAP   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH-1:0]          rnw,
  input  logic [N_CH*DATA_W-1:0]   addr,
  input  logic [N_CH*DATA_W-1:0]   wdata,
  output logic [N_CH-1:0]          gnt,
  output logic [N_CH-1:0]          done,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy,
  output logic                     a_d,
  output logic                     cs,
  output logic                     rd,
  output logic                     wr,
  output logic [DATA_W-1:0]        ad_out,
  output logic                     ad_oe,
  input  logic [DATA_W-1:0]        ad_in
);

  localparam int T_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int CNT_W = $clog2(T_MAX + 1);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {IDLE, A_SET, A_STB, A_HLD, D_STB, D_HLD, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_CH-1:0]     gnt_q, gnt_d;
  logic                rnw_q, rnw_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   addr_q, wdata_q;
  logic [IDX_W-1:0]    pick;
  logic                found;

`ifdef RTC_RR_ARB_EN
  logic [IDX_W-1:0]    ptr_q;

  // Search starts one past the last granted channel and wraps.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(ptr_q) + k) % N_CH;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        ptr_q <= IDX_W'(N_CH - 1);
    else if (state_q == IDLE && found) ptr_q <= pick;
  end
`else
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        pick  = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    rnw_d   = rnw_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (found) begin
        state_d     = A_SET;
        gnt_d       = '0;
        gnt_d[pick] = 1'b1;
        rnw_d       = rnw[pick];
      end
      A_SET: begin
        state_d = A_STB;
        cnt_d   = CNT_W'(T_PULSE - 1);
      end
      A_STB: if (cnt_q == '0) begin
        state_d = A_HLD;
        cnt_d   = CNT_W'(T_GAP - 1);
      end else cnt_d = cnt_q - 1'b1;
      A_HLD: if (cnt_q == '0) begin
        state_d = D_STB;
        cnt_d   = CNT_W'(T_PULSE - 1);
      end else cnt_d = cnt_q - 1'b1;
      D_STB: if (cnt_q == '0) begin
        if (rnw_q) rdata_d = ad_in;
        state_d = D_HLD;
        cnt_d   = CNT_W'(T_GAP - 1);
      end else cnt_d = cnt_q - 1'b1;
      D_HLD: if (cnt_q == '0) state_d = DONE;
             else cnt_d = cnt_q - 1'b1;
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      rnw_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rnw_q   <= rnw_d;
      rdata_q <= rdata_d;
    end
  end

  // Datapath latches need no reset: they only reach the pins outside IDLE.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && found) begin
      addr_q  <= addr[pick*DATA_W +: DATA_W];
      wdata_q <= wdata[pick*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    a_d    = 1'b1;
    cs     = 1'b1;
    rd     = 1'b1;
    wr     = 1'b1;
    ad_oe  = 1'b0;
    ad_out = '0;
    done   = '0;
    case (state_q)
      A_SET, A_HLD: begin
        a_d    = 1'b0;
        ad_oe  = 1'b1;
        ad_out = addr_q;
      end
      A_STB: begin
        a_d    = 1'b0;
        cs     = 1'b0;
        wr     = 1'b0;
        ad_oe  = 1'b1;
        ad_out = addr_q;
      end
      D_STB: begin
        cs = 1'b0;
        if (rnw_q) rd = 1'b0;
        else begin
          wr     = 1'b0;
          ad_oe  = 1'b1;
          ad_out = wdata_q;
        end
      end
      D_HLD: if (!rnw_q) begin
        ad_oe  = 1'b1;
        ad_out = wdata_q;
      end
      DONE:    done = gnt_q;
      default: ;
    endcase
  end

  assign gnt   = gnt_q;
  assign rdata = rdata_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_rtc_bus_seq_arb.sv
// Directed bench: default-parameter instance plus an N_CH=1, T_PULSE=T_GAP=1 instance.
module tb_rtc_bus_seq_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, rnw, gnt, done;
  logic [31:0] addr, wdata;
  logic [7:0]  rdata, ad_out, ad_in;
  logic        busy, a_d, cs, rd, wr, ad_oe;

  logic        req1, rnw1, gnt1, done1, busy1, a_d1, cs1, rd1, wr1, ad_oe1;
  logic [7:0]  addr1, wdata1, rdata1, ad_out1, ad_in1;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  rtc_bus_seq_arb u_dut (
    .clk(clk), .reset(reset), .req(req), .rnw(rnw), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .a_d(a_d), .cs(cs),
    .rd(rd), .wr(wr), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
  );

  rtc_bus_seq_arb #(.N_CH(1), .DATA_W(8), .T_PULSE(1), .T_GAP(1)) u_sml (
    .clk(clk), .reset(reset), .req(req1), .rnw(rnw1), .addr(addr1), .wdata(wdata1),
    .gnt(gnt1), .done(done1), .rdata(rdata1), .busy(busy1), .a_d(a_d1), .cs(cs1),
    .rd(rd1), .wr(wr1), .ad_out(ad_out1), .ad_oe(ad_oe1), .ad_in(ad_in1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Expected {a_d, cs, rd, wr, ad_oe, done_any} for cycle c after the sampling IDLE cycle.
  function automatic logic [5:0] expv(input int c, input bit r, input int tp, input int tg);
    if (c == 1)                 return 6'b011110;
    if (c >= 2 && c < 2+tp)     return 6'b001010;
    if (c >= 2 && c < 2+tp+tg)  return 6'b011110;
    if (c >= 2 && c < 2+2*tp+tg) return r ? 6'b100100 : 6'b101010;
    if (c >= 2 && c < 2+2*tp+2*tg) return r ? 6'b111100 : 6'b111110;
    if (c == 2+2*tp+2*tg)       return 6'b111101;
    return 6'b111100;
  endfunction

  // Runs one transaction starting from a negedge in IDLE; ends at the negedge of the following IDLE cycle.
  task automatic run_txn(input bit sml, input int ch, input bit rd_op, input logic [7:0] a,
                         input logic [7:0] wd, input logic [7:0] rv, input int drop_c);
    int tp, tg, dn, dlast;
    logic [5:0] ov, ev;
    logic [3:0] og, od;
    logic [7:0] oad, ord;
    logic       ob;
    tp    = sml ? 1 : 4;
    tg    = sml ? 1 : 2;
    dn    = 2 + 2*(tp + tg);
    dlast = 1 + 2*tp + tg;
    if (sml) begin
      req1 = 1'b1; rnw1 = rd_op; addr1 = a; wdata1 = wd; ad_in1 = ~rv;
    end else begin
      req[ch] = 1'b1; rnw[ch] = rd_op; addr[ch*8 +: 8] = a; wdata[ch*8 +: 8] = wd; ad_in = ~rv;
    end
    for (int c = 1; c <= dn + 1; c++) begin
      @(negedge clk);
      if (sml) begin
        ov = {a_d1, cs1, rd1, wr1, ad_oe1, done1};
        og = {3'b000, gnt1}; od = {3'b000, done1};
        oad = ad_out1; ord = rdata1; ob = busy1;
      end else begin
        ov = {a_d, cs, rd, wr, ad_oe, |done};
        og = gnt; od = done; oad = ad_out; ord = rdata; ob = busy;
      end
      ev = expv(c, rd_op, tp, tg);
      chk($sformatf("ctl ch%0d c=%0d", ch, c), ov, ev);
      chk($sformatf("gnt ch%0d c=%0d", ch, c), og, (c <= dn) ? (4'b0001 << ch) : 4'b0000);
      chk($sformatf("busy ch%0d c=%0d", ch, c), ob, (c <= dn));
      if (ev[1]) chk($sformatf("ad_out ch%0d c=%0d", ch, c), oad, (c < 2+tp+tg) ? a : wd);
      if (c == dn) chk($sformatf("done ch%0d", ch), od, 4'b0001 << ch);
      if (rd_op && c >= dn) chk($sformatf("rdata ch%0d c=%0d", ch, c), ord, rv);
      if (sml) begin
        ad_in1 = (c == dlast) ? rv : ~rv;
        if (c == drop_c || c == dn) req1 = 1'b0;
      end else begin
        ad_in = (c == dlast) ? rv : ~rv;
        if (c == drop_c || c == dn) req[ch] = 1'b0;
        if (c == 3)
          for (int j = 0; j < 4; j++)
            if (j != ch) begin
              addr[j*8 +: 8]  = 8'hEE;
              wdata[j*8 +: 8] = 8'hDD;
            end
      end
    end
  endtask

  // Strobe sanity on both instances every cycle.
  always @(negedge clk) begin
    chk("strobe big", ((!cs) == (!rd || !wr)) && !(!rd && !wr) && !(!rd && ad_oe), 1);
    chk("strobe sml", ((!cs1) == (!rd1 || !wr1)) && !(!rd1 && !wr1) && !(!rd1 && ad_oe1), 1);
  end

  initial begin
    reset = 1'b1;
    req = '0; rnw = '0; addr = '0; wdata = '0; ad_in = '0;
    req1 = 1'b0; rnw1 = 1'b0; addr1 = '0; wdata1 = '0; ad_in1 = '0;
    repeat (3) @(negedge clk);
    chk("rst ctl", {a_d, cs, rd, wr, ad_oe, |done}, 6'b111100);
    chk("rst gnt", gnt, 4'b0000);
    chk("rst busy", busy, 1'b0);
    chk("rst rdata", rdata, 8'h00);
    chk("rst ad_out", ad_out, 8'h00);
    chk("rst sml ctl", {a_d1, cs1, rd1, wr1, ad_oe1, done1, busy1}, 7'b1111000);
    reset = 1'b0;
    @(negedge clk);

    run_txn(1'b0, 1, 1'b0, 8'h21, 8'h59, 8'h00, 99);
    run_txn(1'b0, 0, 1'b1, 8'hF0, 8'h00, 8'h37, 99);
    run_txn(1'b0, 3, 1'b0, 8'h5A, 8'hC3, 8'h00, 7);
    repeat (2) @(negedge clk);

    // Contention: all four request together and each drops at its own done.
    rnw = '0;
    req = 4'b1111;
    run_txn(1'b0, 0, 1'b0, 8'h10, 8'h01, 8'h00, 99);
`ifdef RTC_RR_ARB_EN
    req[0] = 1'b1;
`endif
    run_txn(1'b0, 1, 1'b1, 8'h11, 8'h00, 8'hA5, 99);
    run_txn(1'b0, 2, 1'b0, 8'h12, 8'h03, 8'h00, 99);
    run_txn(1'b0, 3, 1'b1, 8'h13, 8'h00, 8'h3C, 99);
`ifdef RTC_RR_ARB_EN
    run_txn(1'b0, 0, 1'b0, 8'h14, 8'h05, 8'h00, 99);
`endif
    chk("contention idle", {busy, gnt}, 5'b00000);
    @(negedge clk);

    // Reset during the data strobe of a write.
    req[2] = 1'b1; rnw[2] = 1'b0; addr[16 +: 8] = 8'h44; wdata[16 +: 8] = 8'h99;
    repeat (9) @(negedge clk);
    chk("pre-reset cs/wr", {a_d, cs, wr, ad_oe}, 4'b1001);
    reset = 1'b1; req = '0;
    #1;
    chk("midrst ctl", {a_d, cs, rd, wr, ad_oe, |done}, 6'b111100);
    chk("midrst gnt", gnt, 4'b0000);
    chk("midrst busy", busy, 1'b0);
    @(negedge clk);
    chk("midrst no done", done, 4'b0000);
    reset = 1'b0;
    @(negedge clk);
    chk("post-rst done", done, 4'b0000);
    run_txn(1'b0, 2, 1'b0, 8'h44, 8'h99, 8'h00, 99);

    // Minimal-parameter instance.
    run_txn(1'b1, 0, 1'b0, 8'h7E, 8'h81, 8'h00, 99);
    run_txn(1'b1, 0, 1'b1, 8'h0F, 8'h00, 8'h6B, 99);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
